// File: rtl/deskew_collector.sv
// Re-aligns four staggered accumulator lanes into whole rows and buffers them
// in a 4-entry FIFO, tagging every fourth pushed row as the last row of a tile.
module deskew_collector #(
    parameter int ACC_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [3:0]         in_valid,
    input  logic [4*ACC_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*ACC_W-1:0] out_data,
    output logic               out_last,
    output logic               overflow,
    output logic               skew_err
);
    localparam int ROW_W = 4 * ACC_W;

    // Lane k is delayed by 3-k stages so that all four lanes of one row meet.
    logic [2:0]       v0_q;
    logic [ACC_W-1:0] d0_q [3];
    logic [1:0]       v1_q;
    logic [ACC_W-1:0] d1_q [2];
    logic             v2_q;
    logic [ACC_W-1:0] d2_q;

    logic [3:0]       dly_valid;
    logic [ROW_W-1:0] dly_row;
    logic             aligned_valid;
    logic             skew_seen;

    logic [ROW_W-1:0] mem_data [4];
    logic [3:0]       mem_last;
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       row_cnt;
    logic [2:0]       occ;
    logic             push;
    logic             pop;
    logic             drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q <= '0;
            v1_q <= '0;
            v2_q <= 1'b0;
            d0_q <= '{default: '0};
            d1_q <= '{default: '0};
            d2_q <= '0;
        end else if (clear) begin
            v0_q <= '0;
            v1_q <= '0;
            v2_q <= 1'b0;
            d0_q <= '{default: '0};
            d1_q <= '{default: '0};
            d2_q <= '0;
        end else begin
            v0_q    <= {v0_q[1:0], in_valid[0]};
            d0_q[0] <= in_data[0 +: ACC_W];
            d0_q[1] <= d0_q[0];
            d0_q[2] <= d0_q[1];
            v1_q    <= {v1_q[0], in_valid[1]};
            d1_q[0] <= in_data[ACC_W +: ACC_W];
            d1_q[1] <= d1_q[0];
            v2_q    <= in_valid[2];
            d2_q    <= in_data[2*ACC_W +: ACC_W];
        end
    end

    assign dly_valid     = {in_valid[3], v2_q, v1_q[1], v0_q[2]};
    assign dly_row       = {in_data[3*ACC_W +: ACC_W], d2_q, d1_q[1], d0_q[2]};
    assign aligned_valid = &dly_valid;
    assign skew_seen     = (|dly_valid) && !aligned_valid;

    // Output handshake: a row transfers on a rising edge where out_valid and
    // out_ready are both high; the head row holds still while out_ready is low.
    assign out_valid = (occ != 3'd0);
    assign pop       = out_valid && out_ready;
    assign push      = aligned_valid && ((occ < 3'(FIFO_DEPTH)) || pop);
    assign drop      = aligned_valid && !push;

    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem_data[wr_ptr] <= dly_row;
            mem_last[wr_ptr] <= (row_cnt == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            row_cnt  <= '0;
            occ      <= '0;
            overflow <= 1'b0;
            skew_err <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            row_cnt  <= '0;
            occ      <= '0;
            overflow <= 1'b0;
            skew_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 2'd1;
                row_cnt <= row_cnt + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (skew_seen) begin
                skew_err <= 1'b1;
            end
        end
    end

    // Gating by out_valid keeps stale entries invisible after a pop, clear or reset.
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_last = out_valid && mem_last[rd_ptr];

endmodule

// File: tb/tb_deskew_collector.sv
// Directed bench for deskew_collector: staggered rows in, aligned rows checked
// against a bench-built expected queue, plus flag, reset and clear checks.
module tb_deskew_collector;
    localparam int ACC_W = 16;
    localparam int ROW_W = 4 * ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [3:0]       in_valid;
    logic [ROW_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic             out_last;
    logic             overflow;
    logic             skew_err;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int n_acc = 0;
    int first_acc = 0;
    int last_acc = 0;

    logic [ROW_W-1:0] exp_q[$];
    logic             exp_last_q[$];

    always #5 clk = ~clk;

    deskew_collector #(.ACC_W(ACC_W), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .skew_err  (skew_err)
    );

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] row_val(input logic [15:0] base, input logic [15:0] step, input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v[k*16 +: 16] = base + step * 16'(r) + 16'(k);
        end
        return v;
    endfunction

    task automatic expect_rows(input logic [15:0] base, input logic [15:0] step, input int r0, input int r1, input int last_r);
        for (int r = r0; r <= r1; r++) begin
            exp_q.push_back(row_val(base, step, r));
            exp_last_q.push_back(r == last_r);
        end
    endtask

    // One clock cycle: drive inputs, score any row accepted at the coming edge.
    task automatic cyc(input logic [3:0] v, input logic [ROW_W-1:0] d, input logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        if (out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_row: observed=%h expected=no row", out_data);
            end else begin
                check("row_data", out_data, exp_q.pop_front());
                check("row_last", 64'(out_last), 64'(exp_last_q.pop_front()));
            end
            if (n_acc == 0) first_acc = cyc_n;
            last_acc = cyc_n;
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Presents n back-to-back rows with lane k lagging by k cycles.
    task automatic rows(input int n, input logic [15:0] base, input logic [15:0] step,
                        input int rdy_from, input int skip_row);
        for (int c = 0; c < n + 3; c++) begin
            logic [3:0]       v;
            logic [ROW_W-1:0] d;
            int               r;
            v = '0;
            d = '0;
            for (int k = 0; k < 4; k++) begin
                r = c - k;
                if (r >= 0 && r < n) begin
                    d[k*16 +: 16] = base + step * 16'(r) + 16'(k);
                    if (!(k == 2 && r == skip_row)) v[k] = 1'b1;
                end
            end
            cyc(v, d, c >= rdy_from);
        end
    endtask

    task automatic do_clear();
        in_valid = '0;
        in_data  = '0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        n_acc = 0;
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        in_valid  = 4'hf;
        in_data   = '1;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_skew_err", 64'(skew_err), 64'(0));
        #20;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;

        // Single row: latency 4, then gone one cycle later.
        expect_rows(16'h0010, 16'h0000, 0, 0, -1);
        rows(1, 16'h0010, 16'h0000, 0, -1);
        check("t1_out_valid", 64'(out_valid), 64'(1));
        check("t1_out_data", out_data, 64'h0013_0012_0011_0010);
        check("t1_out_last", 64'(out_last), 64'(0));
        cyc('0, '0, 1'b1);
        check("t1_valid_drop", 64'(out_valid), 64'(0));
        check("t1_drained", 64'(exp_q.size()), 64'(0));

        // Tile of four rows streaming with ready high.
        do_clear();
        expect_rows(16'h0000, 16'h0100, 0, 3, 3);
        rows(4, 16'h0000, 16'h0100, 0, -1);
        cyc('0, '0, 1'b1);
        check("t2_rows", 64'(n_acc), 64'(4));
        check("t2_consecutive", 64'(last_acc - first_acc), 64'(3));
        check("t2_out_valid", 64'(out_valid), 64'(0));
        check("t2_overflow", 64'(overflow), 64'(0));
        check("t2_skew_err", 64'(skew_err), 64'(0));

        // Five rows into a stalled FIFO: fifth dropped, counter not advanced.
        do_clear();
        expect_rows(16'h2000, 16'h0100, 0, 3, 3);
        rows(5, 16'h2000, 16'h0100, 1000, -1);
        check("t3_overflow", 64'(overflow), 64'(1));
        check("t3_occ", 64'(dut.occ), 64'(4));
        check("t3_row_cnt", 64'(dut.row_cnt), 64'(0));
        check("t3_head", out_data, 64'h2003_2002_2001_2000);
        cyc('0, '0, 1'b0);
        cyc('0, '0, 1'b0);
        check("t3_head_hold", out_data, 64'h2003_2002_2001_2000);
        for (int i = 0; i < 4; i++) cyc('0, '0, 1'b1);
        check("t3_empty", 64'(out_valid), 64'(0));
        check("t3_drained", 64'(exp_q.size()), 64'(0));
        check("t3_overflow_sticky", 64'(overflow), 64'(1));

        // Full FIFO with push and pop on the same edge.
        do_clear();
        check("clr_overflow", 64'(overflow), 64'(0));
        check("clr_out_valid", 64'(out_valid), 64'(0));
        expect_rows(16'h3000, 16'h0100, 0, 5, 3);
        rows(6, 16'h3000, 16'h0100, 7, -1);
        check("t4_occ", 64'(dut.occ), 64'(4));
        check("t4_overflow", 64'(overflow), 64'(0));
        for (int i = 0; i < 4; i++) cyc('0, '0, 1'b1);
        check("t4_empty", 64'(out_valid), 64'(0));
        check("t4_drained", 64'(exp_q.size()), 64'(0));

        // Lane 2 withheld for the first row: skew flagged, second row delivered.
        do_clear();
        expect_rows(16'h4000, 16'h0100, 1, 1, -1);
        rows(2, 16'h4000, 16'h0100, 0, 0);
        check("t5_skew_err", 64'(skew_err), 64'(1));
        check("t5_out_valid", 64'(out_valid), 64'(1));
        cyc('0, '0, 1'b1);
        check("t5_drained", 64'(exp_q.size()), 64'(0));
        check("t5_overflow", 64'(overflow), 64'(0));

        // Reset mid-row with a row buffered and skew_err still set.
        rows(1, 16'h5000, 16'h0000, 1000, -1);
        check("t6_pre_valid", 64'(out_valid), 64'(1));
        cyc(4'b0001, 64'h0000_0000_0000_6000, 1'b0);
        cyc(4'b0010, 64'h0000_0000_6001_0000, 1'b0);
        rst      = 1'b1;
        in_valid = 4'b0100;
        #1;
        check("t6_out_valid", 64'(out_valid), 64'(0));
        check("t6_out_data", out_data, '0);
        check("t6_out_last", 64'(out_last), 64'(0));
        check("t6_skew_err", 64'(skew_err), 64'(0));
        check("t6_overflow", 64'(overflow), 64'(0));
        check("t6_row_cnt", 64'(dut.row_cnt), 64'(0));
        #3;
        rst      = 1'b0;
        in_valid = '0;
        expect_rows(16'h7000, 16'h0100, 0, 3, 3);
        rows(4, 16'h7000, 16'h0100, 0, -1);
        cyc('0, '0, 1'b1);
        check("t6_drained", 64'(exp_q.size()), 64'(0));
        check("t6_no_skew", 64'(skew_err), 64'(0));
        check("t6_no_overflow", 64'(overflow), 64'(0));
        check("t6_end_valid", 64'(out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
